// File: rtl/commit_stage_nport_pkg.sv
// Shared types for the N-port commit stage: scoreboard entry, exception, AMO response,
// serialisation FSM encoding and small op-classification helpers.
package commit_stage_nport_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 64;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
  } fu_t;

  typedef enum logic [4:0] {
    ADD, SUB, MUL, LD, SD, FLD, FSD, JALR,
    FENCE, FENCE_I, SFENCE_VMA, CSR_WRITE, CSR_READ,
    AMO_ADDW, AMO_SWAPD, FADD, FMUL, FCVT_F2I
  } fu_op;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] result;
  } amo_resp_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_t             fu;
    fu_op            op;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            valid;
    exception_t      ex;
  } scoreboard_entry_t;

  typedef enum logic [1:0] {SER_IDLE, SER_DRAIN, SER_ISSUE} ser_state_e;
  typedef enum logic [1:0] {SER_FENCE, SER_FENCE_I, SER_SFENCE_VMA} ser_kind_e;

  function automatic logic is_rd_fpr(fu_op op);
    logic r;
    case (op)
      FLD, FADD, FMUL: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_amo(fu_op op);
    logic r;
    case (op)
      AMO_ADDW, AMO_SWAPD: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  // A dcache flush turns any non-store head entry into a FENCE.I-like barrier.
  function automatic logic is_serialising(scoreboard_entry_t e, logic flush_dcache);
    logic r;
    case (e.op)
      FENCE, FENCE_I, SFENCE_VMA: r = 1'b1;
      default:                    r = flush_dcache && (e.fu != STORE);
    endcase
    return r;
  endfunction

  function automatic ser_kind_e ser_kind(fu_op op, logic flush_dcache);
    ser_kind_e k;
    case (op)
      SFENCE_VMA: k = SER_SFENCE_VMA;
      FENCE:      k = flush_dcache ? SER_FENCE_I : SER_FENCE;
      default:    k = SER_FENCE_I;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/commit_stage_nport_if.sv
// Scoreboard / register-file side of the commit stage: head entries in, acks and writes out.
interface commit_stage_nport_if
  import commit_stage_nport_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2
) ();

  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]           commit_instr_i;
  logic              [NR_COMMIT_PORTS-1:0]           commit_ack_o;
  logic              [NR_COMMIT_PORTS-1:0][4:0]      waddr_o;
  logic              [NR_COMMIT_PORTS-1:0][XLEN-1:0] wdata_o;
  logic              [NR_COMMIT_PORTS-1:0]           we_gpr_o;
  logic              [NR_COMMIT_PORTS-1:0]           we_fpr_o;

  modport master (
    output commit_instr_i,
    input  commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o
  );

  modport slave (
    input  commit_instr_i,
    output commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o
  );

endinterface

// File: rtl/commit_stage_nport_watchdog.sv
// Saturating stall counter for the head entry; flags when port 0 has waited STALL_TIMEOUT cycles.
module commit_stage_nport_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic ack_i,
  input  logic halt_i,
  output logic stall_timeout_o
);

  localparam int unsigned CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Halt freezes the count rather than clearing it.
  always_comb begin
    cnt_d = cnt_q;
    if (!valid_i || ack_i) begin
      cnt_d = '0;
    end else if (!halt_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/commit_stage_nport.sv
// In-order N-wide commit stage with FENCE/FENCE.I/SFENCE.VMA serialisation, retire count
// and a port-0 stall watchdog.
module commit_stage_nport
  import commit_stage_nport_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned STALL_TIMEOUT   = 1024
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     halt_i,
  input  logic                                     flush_dcache_i,
  input  logic                                     single_step_i,
  commit_stage_nport_if.slave                      cif,
  input  amo_resp_t                                amo_resp_i,
  output logic                                     amo_valid_commit_o,
  output logic [VLEN-1:0]                          pc_o,
  output fu_op                                     csr_op_o,
  output logic [XLEN-1:0]                          csr_wdata_o,
  input  logic [XLEN-1:0]                          csr_rdata_i,
  input  exception_t                               csr_exception_i,
  output logic                                     csr_write_fflags_o,
  output logic                                     commit_csr_o,
  output logic                                     commit_lsu_o,
  input  logic                                     commit_lsu_ready_i,
  input  logic                                     no_st_pending_i,
  output logic                                     fence_o,
  output logic                                     fence_i_o,
  output logic                                     sfence_vma_o,
  output logic                                     flush_commit_o,
  output exception_t                               exception_o,
  output logic [$clog2(NR_COMMIT_PORTS+1)-1:0]     retire_cnt_o,
  output logic                                     stall_timeout_o
);

  localparam int unsigned RCW = $clog2(NR_COMMIT_PORTS + 1);

  scoreboard_entry_t            p0_s;
  logic                         p0_ok_s, ser_p0_s, p0_blocks_s, unused_s;
  logic [NR_COMMIT_PORTS-1:0]   ack_s, we_gpr_s, we_fpr_s;
  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] wdata_s;
  logic [RCW-1:0]               cnt_s;
  ser_state_e                   state_q;
  ser_kind_e                    kind_q;
  logic                         fence_q, fence_i_q, sfence_q;

  assign p0_s        = cif.commit_instr_i[0];
  assign p0_ok_s     = p0_s.valid && !p0_s.ex.valid && !halt_i;
  assign ser_p0_s    = is_serialising(p0_s, flush_dcache_i);
  assign p0_blocks_s = (p0_s.fu == CSR) || ((p0_s.fu == STORE) && is_amo(p0_s.op)) || ser_p0_s;

  // Serialisation FSM; the pulse registers are loaded on DRAIN->ISSUE so they line up with ISSUE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SER_IDLE;
      kind_q    <= SER_FENCE;
      fence_q   <= 1'b0;
      fence_i_q <= 1'b0;
      sfence_q  <= 1'b0;
    end else begin
      fence_q   <= 1'b0;
      fence_i_q <= 1'b0;
      sfence_q  <= 1'b0;
      case (state_q)
        SER_IDLE: begin
          if (ser_p0_s && p0_ok_s) begin
            state_q <= SER_DRAIN;
            kind_q  <= ser_kind(p0_s.op, flush_dcache_i);
          end
        end
        SER_DRAIN: begin
          if (halt_i || !p0_s.valid) begin
            state_q <= SER_IDLE;
          end else if (no_st_pending_i) begin
            state_q   <= SER_ISSUE;
            fence_q   <= (kind_q == SER_FENCE);
            fence_i_q <= (kind_q == SER_FENCE_I);
            sfence_q  <= (kind_q == SER_SFENCE_VMA);
          end
        end
        SER_ISSUE: state_q <= SER_IDLE;
        default:   state_q <= SER_IDLE;
      endcase
    end
  end

  // Commit decision for all ports; everything here is zero-latency from the inputs.
  always_comb begin
    ack_s              = '0;
    we_gpr_s           = '0;
    we_fpr_s           = '0;
    amo_valid_commit_o = 1'b0;
    csr_op_o           = ADD;
    csr_wdata_o        = '0;
    csr_write_fflags_o = 1'b0;
    commit_csr_o       = 1'b0;
    commit_lsu_o       = 1'b0;
    flush_commit_o     = 1'b0;
    exception_o        = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      wdata_s[i] = cif.commit_instr_i[i].result;
    end
    if (!rst_i) begin
      if (p0_s.valid && !halt_i) begin
        if (p0_s.ex.valid) begin
          exception_o = p0_s.ex;
        end else if (csr_exception_i.valid) begin
          exception_o      = csr_exception_i;
          exception_o.tval = p0_s.ex.tval;
        end else begin
          exception_o = '0;
        end
      end
      if (state_q == SER_ISSUE) begin
        ack_s[0]    = 1'b1;
        we_gpr_s[0] = !is_rd_fpr(p0_s.op);
        we_fpr_s[0] = is_rd_fpr(p0_s.op);
      end else if ((state_q == SER_IDLE) && p0_ok_s && !ser_p0_s) begin
        ack_s[0]    = 1'b1;
        we_gpr_s[0] = !is_rd_fpr(p0_s.op);
        we_fpr_s[0] = is_rd_fpr(p0_s.op);
        case (p0_s.fu)
          STORE: begin
            if (is_amo(p0_s.op)) begin
              amo_valid_commit_o = 1'b1;
              ack_s[0]           = amo_resp_i.ack;
              we_gpr_s[0]        = amo_resp_i.ack;
              we_fpr_s[0]        = 1'b0;
              flush_commit_o     = amo_resp_i.ack;
              if (amo_resp_i.ack) begin
                wdata_s[0] = amo_resp_i.result;
              end
            end else begin
              ack_s[0]     = commit_lsu_ready_i;
              commit_lsu_o = commit_lsu_ready_i;
              we_gpr_s[0]  = we_gpr_s[0] && commit_lsu_ready_i;
              we_fpr_s[0]  = we_fpr_s[0] && commit_lsu_ready_i;
            end
          end
          FPU, FPU_VEC: begin
            csr_write_fflags_o = 1'b1;
            csr_wdata_o        = {{(XLEN-5){1'b0}}, p0_s.ex.cause[4:0]};
          end
          CSR: begin
            csr_op_o    = p0_s.op;
            csr_wdata_o = p0_s.result;
            if (csr_exception_i.valid) begin
              ack_s[0]    = 1'b0;
              we_gpr_s[0] = 1'b0;
              we_fpr_s[0] = 1'b0;
            end else begin
              commit_csr_o = 1'b1;
              wdata_s[0]   = csr_rdata_i;
            end
          end
          default: ;
        endcase
      end else begin
        ack_s[0] = 1'b0;
      end
      for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
        if (ack_s[i-1] && !p0_blocks_s && !flush_dcache_i && !single_step_i && !exception_o.valid &&
            cif.commit_instr_i[i].valid && !cif.commit_instr_i[i].ex.valid &&
            (cif.commit_instr_i[i].fu inside {ALU, LOAD, CTRL_FLOW, MULT, FPU, FPU_VEC})) begin
          ack_s[i]    = 1'b1;
          we_gpr_s[i] = !is_rd_fpr(cif.commit_instr_i[i].op);
          we_fpr_s[i] = is_rd_fpr(cif.commit_instr_i[i].op);
          if (cif.commit_instr_i[i].fu inside {FPU, FPU_VEC}) begin
            csr_write_fflags_o = 1'b1;
            csr_wdata_o[4:0]   = csr_wdata_o[4:0] | cif.commit_instr_i[i].ex.cause[4:0];
          end
        end
      end
    end
  end

  // Population count of this cycle's acknowledges.
  always_comb begin
    cnt_s = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      cnt_s = cnt_s + RCW'(ack_s[i]);
    end
  end

  // Fields consumed only at port 0 are gathered here so the other ports' copies do not dangle.
  always_comb begin
    unused_s = 1'b0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      unused_s = unused_s ^ (^{cif.commit_instr_i[i].pc, cif.commit_instr_i[i].ex.tval,
                               cif.commit_instr_i[i].ex.cause});
    end
  end

  for (genvar g = 0; g < NR_COMMIT_PORTS; g++) begin : g_waddr
    assign cif.waddr_o[g] = cif.commit_instr_i[g].rd;
  end

  assign cif.commit_ack_o = ack_s;
  assign cif.wdata_o      = wdata_s;
  assign cif.we_gpr_o     = we_gpr_s;
  assign cif.we_fpr_o     = we_fpr_s;
  assign retire_cnt_o     = cnt_s;
  assign pc_o             = p0_s.pc;
  assign fence_o          = fence_q;
  assign fence_i_o        = fence_i_q;
  assign sfence_vma_o     = sfence_q;

  commit_stage_nport_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (p0_s.valid),
    .ack_i           (ack_s[0]),
    .halt_i          (halt_i),
    .stall_timeout_o (stall_timeout_o)
  );

endmodule
